// File: rtl/ct_biu_arb_pkg.sv
// Shared constants for the BIU read-address arbiter: mode encodings,
// default payload width and the bit layout of a packed AR payload.
package ct_biu_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  localparam int AR_PLD_W   = 64;

  localparam int AR_ADDR_LSB   = 0;   // 40 bits
  localparam int AR_ID_LSB     = 40;  // 5 bits
  localparam int AR_LEN_LSB    = 45;  // 2 bits
  localparam int AR_SIZE_LSB   = 47;  // 3 bits
  localparam int AR_BURST_LSB  = 50;  // 2 bits
  localparam int AR_LOCK_LSB   = 52;  // 1 bit
  localparam int AR_CACHE_LSB  = 53;  // 4 bits
  localparam int AR_PROT_LSB   = 57;  // 3 bits
  localparam int AR_SNOOP_LSB  = 60;  // 1 bit
  localparam int AR_DOMAIN_LSB = 61;  // 1 bit
  localparam int AR_BAR_LSB    = 62;  // 1 bit
  localparam int AR_USER_LSB   = 63;  // 1 bit

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ct_biu_rr_pick.sv
// Round-robin picker: one-hot first requester at or above i_ptr, wrapping to 0.
// Purely combinational; no state and no backpressure.
module ct_biu_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [2:0]   i_ptr,
  output logic [N-1:0] o_gnt
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (3'(i) >= i_ptr);
    end
  end

  // Requesters at/above the pointer win first; otherwise wrap to the full set.
  assign w_hi  = i_req & w_mask;
  assign w_sel = (|w_hi) ? w_hi : i_req;
  assign o_gnt = w_sel & (-w_sel);

endmodule

// File: rtl/ct_biu_ar_arb_n.sv
// N-source AR arbiter into one registered AR slot; request-to-arvalid latency 1 cycle.
// Backpressure: grants only when the slot is empty or draining (arready), otherwise held.
module ct_biu_ar_arb_n
  import ct_biu_arb_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int PLD_W      = AR_PLD_W,
  parameter int MODE       = MODE_RR,
  parameter int STARVE_MAX = 4
) (
  input  logic                     cpuclk,
  input  logic                     cpurst,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*PLD_W-1:0] src_pld,
  output logic [NUM_SRC-1:0]       src_grnt,
  output logic                     arvalid,
  output logic [PLD_W-1:0]         arpld,
  output logic [2:0]               arsrc,
  input  logic                     arready,
  output logic                     arvalid_gate
);

  logic               r_arvalid;
  logic [PLD_W-1:0]   r_arpld;
  logic [2:0]         r_arsrc;
  logic [2:0]         r_ptr;
  logic [3:0]         r_starve_cnt;

  logic               w_load_en;
  logic [NUM_SRC-1:0] w_rr_gnt;
  logic [NUM_SRC-1:0] w_fx_gnt;
  logic [NUM_SRC-1:0] w_oth;
  logic               w_oth_req;
  logic [NUM_SRC-1:0] w_win;
  logic [7:0]         w_win8;
  logic [2:0]         w_idx;
  logic               w_any_gnt;
  logic [PLD_W-1:0]   w_sel_pld;

  ct_biu_rr_pick #(.N(NUM_SRC)) u_rr_pick (
    .i_req (src_req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  assign w_load_en = !r_arvalid || arready;

  // Fixed priority, with index 0 forced aside once it has starved the others.
  assign w_oth     = {src_req[NUM_SRC-1:1], 1'b0};
  assign w_oth_req = |w_oth;
  assign w_fx_gnt  = ((r_starve_cnt >= 4'(STARVE_MAX)) && w_oth_req) ?
                     (w_oth & (-w_oth)) : (src_req & (-src_req));

  assign w_win     = (MODE == MODE_RR) ? w_rr_gnt : w_fx_gnt;
  assign src_grnt  = (w_load_en && !cpurst) ? w_win : '0;
  assign w_any_gnt = |src_grnt;

  always_comb begin
    w_win8 = '0;
    w_win8[NUM_SRC-1:0] = w_win;
  end

  assign w_idx = oh2idx(w_win8);

  always_comb begin
    w_sel_pld = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_win[i]) w_sel_pld = src_pld[i*PLD_W +: PLD_W];
    end
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      r_arvalid    <= 1'b0;
      r_arpld      <= '0;
      r_arsrc      <= 3'd0;
      r_ptr        <= 3'd0;
      r_starve_cnt <= 4'd0;
    end else begin
      if (w_any_gnt) begin
        r_arvalid <= 1'b1;
        r_arpld   <= w_sel_pld;
        r_arsrc   <= w_idx;
      end else if (r_arvalid && arready) begin
        r_arvalid <= 1'b0;
      end

      if ((MODE == MODE_RR) && w_any_gnt) begin
        r_ptr <= (w_idx == 3'(NUM_SRC-1)) ? 3'd0 : w_idx + 3'd1;
      end

      if (MODE == MODE_FIXED) begin
        if (!w_oth_req || (w_any_gnt && !w_win[0])) begin
          r_starve_cnt <= 4'd0;
        end else if (w_any_gnt && (r_starve_cnt != 4'hF)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end
    end
  end

  assign arvalid      = r_arvalid;
  assign arpld        = r_arpld;
  assign arsrc        = r_arsrc;
  assign arvalid_gate = r_arvalid | (|src_req);

endmodule

// File: tb/tb_ct_biu_ar_arb_n.sv
// Bench for ct_biu_ar_arb_n: a round-robin and a fixed-priority instance share
// stimulus; directed scenarios plus a randomized run against a queue-based model.
module tb_ct_biu_ar_arb_n;
  import ct_biu_arb_pkg::*;

  localparam int N = 3;
  localparam int W = 64;

  logic           cpuclk = 1'b0;
  logic           cpurst = 1'b1;
  logic [N-1:0]   src_req = '0;
  logic [N*W-1:0] src_pld = '0;
  logic           arready = 1'b0;

  logic [N-1:0] rr_grnt, fx_grnt;
  logic         rr_vld, fx_vld, rr_gate, fx_gate;
  logic [W-1:0] rr_pld, fx_pld;
  logic [2:0]   rr_src, fx_src;

  int vectors = 0;
  int miscompares = 0;

  always #5 cpuclk = ~cpuclk;

  ct_biu_ar_arb_n #(.NUM_SRC(N), .PLD_W(W), .MODE(MODE_RR), .STARVE_MAX(4)) u_rr (
    .cpuclk(cpuclk), .cpurst(cpurst), .src_req(src_req), .src_pld(src_pld),
    .src_grnt(rr_grnt), .arvalid(rr_vld), .arpld(rr_pld), .arsrc(rr_src),
    .arready(arready), .arvalid_gate(rr_gate)
  );

  ct_biu_ar_arb_n #(.NUM_SRC(N), .PLD_W(W), .MODE(MODE_FIXED), .STARVE_MAX(4)) u_fx (
    .cpuclk(cpuclk), .cpurst(cpurst), .src_req(src_req), .src_pld(src_pld),
    .src_grnt(fx_grnt), .arvalid(fx_vld), .arpld(fx_pld), .arsrc(fx_src),
    .arready(arready), .arvalid_gate(fx_gate)
  );

  typedef struct {
    logic [2:0]   src;
    logic [W-1:0] pld;
  } beat_t;

  function automatic logic [W-1:0] pat(input int i);
    return {32'hA0A0_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
  endfunction

  task automatic next_cycle();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic do_reset();
    cpurst  = 1'b1;
    src_req = '0;
    arready = 1'b0;
    src_pld = {pat(2), pat(1), pat(0)};
    next_cycle();
    next_cycle();
    cpurst = 1'b0;
  endtask

  task automatic test_reset();
    cpurst  = 1'b1;
    src_req = 3'b111;
    arready = 1'b1;
    src_pld = {pat(2), pat(1), pat(0)};
    next_cycle();
    next_cycle();
    @(negedge cpuclk);
    vectors++; if (rr_grnt !== 3'b000 || fx_grnt !== 3'b000) begin miscompares++;
      $display("FAIL reset_grnt rr=%b fx=%b want 000", rr_grnt, fx_grnt); end
    vectors++; if (rr_vld !== 1'b0 || fx_vld !== 1'b0) begin miscompares++;
      $display("FAIL reset_vld rr=%b fx=%b want 0", rr_vld, fx_vld); end
    vectors++; if (rr_pld !== '0 || rr_src !== 3'd0 || fx_pld !== '0 || fx_src !== 3'd0) begin
      miscompares++; $display("FAIL reset_regs pld=%h src=%0d want 0", rr_pld, rr_src); end
    vectors++; if (rr_gate !== 1'b1) begin miscompares++;
      $display("FAIL reset_gate got %b want 1", rr_gate); end
    next_cycle();
    cpurst = 1'b0;
    @(negedge cpuclk);
    vectors++; if (rr_grnt !== 3'b001 || fx_grnt !== 3'b001) begin miscompares++;
      $display("FAIL first_grant rr=%b fx=%b want 001", rr_grnt, fx_grnt); end
    next_cycle();
    vectors++; if (rr_vld !== 1'b1 || rr_src !== 3'd0 || rr_pld !== pat(0)) begin miscompares++;
      $display("FAIL first_beat vld=%b src=%0d pld=%h want 1/0/%h", rr_vld, rr_src, rr_pld, pat(0)); end
  endtask

  task automatic test_rr_rotation();
    logic [N-1:0] exp;
    do_reset();
    src_req = 3'b111;
    arready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge cpuclk);
      exp = 3'(1 << (c % 3));
      vectors++; if (rr_grnt !== exp) begin miscompares++;
        $display("FAIL rr_rot_grnt c=%0d got %b want %b", c, rr_grnt, exp); end
      if (c > 0) begin
        vectors++;
        if (rr_vld !== 1'b1 || rr_src !== 3'((c - 1) % 3) || rr_pld !== pat((c - 1) % 3)) begin
          miscompares++;
          $display("FAIL rr_rot_beat c=%0d vld=%b src=%0d want 1/%0d", c, rr_vld, rr_src, (c - 1) % 3);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    do_reset();
    src_req = 3'b001;
    next_cycle();
    src_req = 3'b110;
    src_pld = {pat(2), pat(1), pat(7)};
    for (int c = 0; c < 5; c++) begin
      @(negedge cpuclk);
      vectors++; if (rr_grnt !== 3'b000 || fx_grnt !== 3'b000) begin miscompares++;
        $display("FAIL stall_grnt c=%0d rr=%b fx=%b want 000", c, rr_grnt, fx_grnt); end
      vectors++; if (rr_vld !== 1'b1 || rr_pld !== pat(0) || rr_src !== 3'd0) begin miscompares++;
        $display("FAIL stall_hold c=%0d vld=%b pld=%h want 1/%h", c, rr_vld, rr_pld, pat(0)); end
      next_cycle();
    end
    arready = 1'b1;
    @(negedge cpuclk);
    vectors++; if (rr_grnt !== 3'b010 || fx_grnt !== 3'b010) begin miscompares++;
      $display("FAIL stall_release rr=%b fx=%b want 010", rr_grnt, fx_grnt); end
    next_cycle();
    src_req = 3'b000;
    vectors++; if (rr_vld !== 1'b1 || rr_src !== 3'd1 || rr_pld !== pat(1)) begin miscompares++;
      $display("FAIL stall_newbeat src=%0d pld=%h want 1/%h", rr_src, rr_pld, pat(1)); end
    next_cycle();
    @(negedge cpuclk);
    vectors++; if (rr_vld !== 1'b0 || rr_grnt !== 3'b000 || rr_gate !== 1'b0) begin miscompares++;
      $display("FAIL drain_idle vld=%b grnt=%b gate=%b want 0", rr_vld, rr_grnt, rr_gate); end
    next_cycle();
  endtask

  task automatic test_starve();
    int exp_idx[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    src_req = 3'b011;
    arready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge cpuclk);
      vectors++; if (fx_grnt !== 3'(1 << exp_idx[c])) begin miscompares++;
        $display("FAIL starve_grnt c=%0d got %b want idx %0d", c, fx_grnt, exp_idx[c]); end
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    arready = 1'b1;
    src_req = 3'b010;
    next_cycle();
    src_req = 3'b001;
    @(negedge cpuclk);
    vectors++; if (rr_grnt !== 3'b001) begin miscompares++;
      $display("FAIL wrap_grnt got %b want 001", rr_grnt); end
    next_cycle();
    src_req = 3'b111;
    @(negedge cpuclk);
    vectors++; if (rr_grnt !== 3'b010 || rr_src !== 3'd0) begin miscompares++;
      $display("FAIL wrap_ptr grnt=%b src=%0d want 010/0", rr_grnt, rr_src); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_req = 3'b010;
    next_cycle();
    cpurst = 1'b1;
    @(negedge cpuclk);
    vectors++; if (rr_grnt !== 3'b000 || rr_vld !== 1'b1) begin miscompares++;
      $display("FAIL rstmid_grnt grnt=%b vld=%b want 000/1", rr_grnt, rr_vld); end
    next_cycle();
    cpurst  = 1'b0;
    src_req = 3'b111;
    @(negedge cpuclk);
    vectors++; if (rr_vld !== 1'b0 || rr_src !== 3'd0 || rr_pld !== '0) begin miscompares++;
      $display("FAIL rstmid_drop vld=%b src=%0d want 0/0", rr_vld, rr_src); end
    vectors++; if (rr_grnt !== 3'b001 || fx_grnt !== 3'b001) begin miscompares++;
      $display("FAIL rstmid_first rr=%b fx=%b want 001", rr_grnt, fx_grnt); end
    next_cycle();
  endtask

  task automatic test_random_stress();
    beat_t        q_rr[$];
    beat_t        q_fx[$];
    beat_t        b;
    logic [W-1:0] pl[N];
    logic [N-1:0] pend, rq, exp;
    int           wait_b[N];
    int           rr_ptr, fx_cnt, rr_w, fx_w, j;
    logic         others;
    do_reset();
    rr_ptr = 0;
    fx_cnt = 0;
    pend   = '0;
    for (int i = 0; i < N; i++) wait_b[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]   = 1'b1;
          wait_b[i] = 0;
        end
        pl[i] = {$urandom, $urandom};
      end
      src_req = pend;
      src_pld = {pl[2], pl[1], pl[0]};
      arready = ($urandom_range(0, 3) != 0);
      rq      = pend;
      @(negedge cpuclk);

      rr_w = -1;
      for (int k = 0; k < N; k++) begin
        j = (rr_ptr + k) % N;
        if (rr_w < 0 && rq[j]) rr_w = j;
      end
      if (q_rr.size() != 0 && !arready) rr_w = -1;
      exp = (rr_w < 0) ? '0 : 3'(1 << rr_w);
      vectors++; if (rr_grnt !== exp) begin miscompares++;
        $display("FAIL rnd_rr_grnt cyc=%0d got %b want %b", cyc, rr_grnt, exp); end
      vectors++; if (rr_vld !== (q_rr.size() != 0)) begin miscompares++;
        $display("FAIL rnd_rr_vld cyc=%0d got %b want %0d", cyc, rr_vld, q_rr.size()); end
      if (q_rr.size() != 0 && arready) begin
        b = q_rr.pop_front();
        vectors++; if (rr_src !== b.src || rr_pld !== b.pld) begin miscompares++;
          $display("FAIL rnd_rr_beat cyc=%0d src=%0d pld=%h want %0d/%h", cyc, rr_src, rr_pld, b.src, b.pld); end
      end
      if (rr_w >= 0) begin
        q_rr.push_back('{src: 3'(rr_w), pld: pl[rr_w]});
        vectors++; if (wait_b[rr_w] > N - 1) begin miscompares++;
          $display("FAIL rnd_rr_starve src=%0d waited %0d beats want <= %0d", rr_w, wait_b[rr_w], N - 1); end
        for (int i = 0; i < N; i++) if (pend[i] && i != rr_w) wait_b[i]++;
        pend[rr_w] = 1'b0;
        rr_ptr     = (rr_w + 1) % N;
      end

      others = |rq[N-1:1];
      fx_w = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (rq[i] && !(fx_cnt >= 4 && others && i == 0)) fx_w = i;
      end
      if (q_fx.size() != 0 && !arready) fx_w = -1;
      exp = (fx_w < 0) ? '0 : 3'(1 << fx_w);
      vectors++; if (fx_grnt !== exp) begin miscompares++;
        $display("FAIL rnd_fx_grnt cyc=%0d got %b want %b cnt=%0d", cyc, fx_grnt, exp, fx_cnt); end
      if (q_fx.size() != 0 && arready) begin
        b = q_fx.pop_front();
        vectors++; if (fx_vld !== 1'b1 || fx_src !== b.src || fx_pld !== b.pld) begin miscompares++;
          $display("FAIL rnd_fx_beat cyc=%0d src=%0d want %0d", cyc, fx_src, b.src); end
      end
      if (fx_w >= 0) q_fx.push_back('{src: 3'(fx_w), pld: pl[fx_w]});
      if (!others)        fx_cnt = 0;
      else if (fx_w == 0) fx_cnt = (fx_cnt < 15) ? fx_cnt + 1 : 15;
      else if (fx_w > 0)  fx_cnt = 0;

      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_stall();
    test_starve();
    test_wrap();
    test_reset_mid();
    test_random_stress();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ct_biu_ar_arb_n.md
CT_BIU_AR_ARB_N -- requirements
Module: ct_biu_ar_arb_n

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named as below.
REQ-002 The block SHALL provide parameter NUM_SRC, default 3: number of read-address requesters, legal range 2..8.
REQ-003 The block SHALL provide parameter PLD_W, default 64: width of each packed AR payload (addr, id, len, size, burst, lock, cache, prot, snoop, domain, bar, user).
REQ-004 The block SHALL provide parameter MODE, default 1: 0 = fixed priority (index 0 highest), 1 = round robin.
REQ-005 The block SHALL provide parameter STARVE_MAX, default 4: fixed-mode limit on consecutive index-0 grants while another source waits; range 1..15.
REQ-006 cpuclk  in  1  clock.
REQ-007 cpurst  in  1  synchronous active-high reset.
REQ-008 src_req  in  NUM_SRC  per-source request; held until granted.
REQ-009 src_pld  in  NUM_SRC*PLD_W  per-source payload, slice i at [i*PLD_W +: PLD_W].
REQ-010 src_grnt  out  NUM_SRC  one-hot per-cycle acceptance.
REQ-011 arvalid  out  1  registered output valid.
REQ-012 arpld  out  PLD_W  registered output payload.
REQ-013 arsrc  out  3  index of the source held in the output register.
REQ-014 arready  in  1  downstream ready.
REQ-015 arvalid_gate  out  1  clock-gate hint: arvalid OR any src_req.

Function
REQ-016 Output register "load enable" SHALL be defined as: load_en = !arvalid || arready.
REQ-017 src_grnt[i] SHALL be 1 only when src_req[i], i is the arbitration winner and load_en; at most one bit SHALL be set.
REQ-018 A grant SHALL load src_pld slice i into arpld and i into arsrc, and set arvalid=1 at the next clock edge; latency from request to arvalid is 1 cycle.
REQ-019 When arvalid && arready and there is no grant in the same cycle, arvalid SHALL clear next cycle.
REQ-020 When arvalid && arready and there is a grant in the same cycle, a back-to-back reload SHALL give one beat per cycle with no bubble.
REQ-021 While arvalid && !arready, arpld and arsrc SHALL stay stable and src_grnt SHALL be 0 (AXI stability).
REQ-022 In MODE 1, the winner SHALL be the first requester at or after pointer ptr, searching upward and wrapping at NUM_SRC-1 to 0.
REQ-023 In MODE 1, on a grant to index w, ptr SHALL become (w+1) mod NUM_SRC; ptr SHALL be unchanged when there is no grant.
REQ-024 In MODE 0, the winner SHALL be the lowest-index requester, except as given in REQ-025.
REQ-025 In MODE 0, starve_cnt (4 bits) SHALL increment on each grant to index 0 while any other src_req is high.
REQ-026 In MODE 0, when starve_cnt reaches STARVE_MAX, the next grant SHALL go to the lowest-index requester among 1..NUM_SRC-1, and starve_cnt SHALL then clear.
REQ-027 In MODE 0, starve_cnt SHALL clear on any grant to a non-zero index, and SHALL clear when no other source is requesting.
REQ-028 When no requester is present, there SHALL be no grant and state SHALL hold.
REQ-029 Unused arsrc upper bits SHALL be 0.

Reset
REQ-030 While cpurst=1, the block SHALL hold arvalid=0, arpld=0, arsrc=0, ptr=0 and starve_cnt=0, and SHALL force src_grnt=0.
REQ-031 Reset asserted mid-transfer SHALL drop arvalid at the next edge regardless of arready; the pending beat SHALL be discarded.
REQ-032 The first grant after reset deassertion SHALL be available in the first cycle with cpurst=0.

Structure
REQ-033 Package ct_biu_arb_pkg SHALL hold the MODE_FIXED/MODE_RR constants, the default PLD_W, and the AR payload field offsets.
REQ-034 Round-robin search SHALL live in sub-module ct_biu_rr_pick (inputs: req vector, ptr; output: one-hot winner), instantiated once.

Verification
REQ-035 MODE1, NUM_SRC=3, src_req=3'b111 held, arready=1: grants SHALL go 0,1,2,0,1,2 on consecutive cycles, arvalid continuously 1.
REQ-036 arready=0 for 5 cycles with arvalid=1: arpld SHALL stay stable, src_grnt=0; arready=1 on cycle 6 SHALL give a same-cycle grant and the new payload on cycle 7.
REQ-037 MODE0, STARVE_MAX=4, src_req=3'b011 held, arready=1: index 0 SHALL be granted 4 times, then index 1 once, then the pattern repeats.
REQ-038 MODE1, ptr=2, only src_req[0]=1: grant SHALL go to 0 (wrap-around) and ptr SHALL become 1.
REQ-039 cpurst pulsed while arvalid=1, arready=0: arvalid=0 the next cycle, ptr=0, and the first post-reset grant goes to the lowest requester.
REQ-040 A random stress run SHALL find no grant while stalled, no lost or duplicated beat (scoreboard of src index and payload), and every requester granted within NUM_SRC beats in MODE 1.
